// File: rtl/snn_pkg.sv
// Shared FSM encodings, config selectors and saturating arithmetic for the LIF scheduler.
package snn_pkg;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REWARD = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic CFG_WEIGHT = 1'b0;
    localparam logic CFG_THRESH = 1'b1;

    // Callers zero-extend operands to 32 bits and truncate the result to their own width.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] max);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max}) ? max : s[31:0];
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? 32'd0 : a - b;
    endfunction
endpackage

// File: rtl/snn_lif_update.sv
// Combinational leak / integrate / fire datapath shared by all neurons of the sweep.
module snn_lif_update
    import snn_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int LEAK_SHIFT   = 2,
    parameter int REFRAC_STEPS = 1,
    parameter int VW           = WIDTH + 4,
    parameter int RW           = 1
) (
    input  logic [VW-1:0]    v,
    input  logic [WIDTH-1:0] w,
    input  logic             spk,
    input  logic [RW-1:0]    refrac,
    input  logic [VW-1:0]    thresh,
    output logic [VW-1:0]    v_nxt,
    output logic [RW-1:0]    refrac_nxt,
    output logic             fire
);
    localparam logic [31:0] VMAX = (32'd1 << VW) - 32'd1;

    logic [VW-1:0] v_l;
    logic [VW-1:0] v_int;

    always_comb begin
        v_l        = v - (v >> LEAK_SHIFT);
        v_int      = VW'(sat_add(32'(v_l), spk ? 32'(w) : 32'd0, VMAX));
        v_nxt      = v_l;
        refrac_nxt = refrac;
        fire       = 1'b0;
        // Refractory neurons still leak but ignore their input.
        if (refrac != '0) begin
            refrac_nxt = refrac - RW'(1);
        end else if (v_int > thresh) begin
            fire       = 1'b1;
            v_nxt      = '0;
            refrac_nxt = RW'(REFRAC_STEPS);
        end else begin
            v_nxt = v_int;
        end
    end
endmodule

// File: rtl/snn_lif_scheduler.sv
// Sequences reward and LIF update sweeps over NUM_NEURONS neurons; owns all neuron state.
module snn_lif_scheduler
    import snn_pkg::*;
#(
    parameter int NUM_NEURONS  = 4,
    parameter int WIDTH        = 4,
    parameter int LEAK_SHIFT   = 2,
    parameter int REFRAC_STEPS = 1,
    parameter int WEIGHT_INIT  = 4,
    parameter int THRESH_INIT  = 8,
    parameter int VW           = WIDTH + 4,
    parameter int IW           = $clog2(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   step_i,
    input  logic [NUM_NEURONS-1:0] spk_in,
    input  logic                   reward_valid,
    input  logic                   reward_pos,
    input  logic                   cfg_we,
    input  logic                   cfg_sel,
    input  logic [IW-1:0]          cfg_addr,
    input  logic [VW-1:0]          cfg_data,
    output logic                   cfg_ready,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_NEURONS-1:0] spk_out
);
    localparam int RW = (REFRAC_STEPS < 1) ? 1 : $clog2(REFRAC_STEPS + 1);
    localparam logic [31:0] WMAX = (32'd1 << WIDTH) - 32'd1;

    logic [1:0]                             state;
    logic [IW-1:0]                          idx;
    logic [NUM_NEURONS-1:0]                 spk_in_q;
    logic                                   rew_pos_q;
    logic [NUM_NEURONS-1:0][VW-1:0]         vmem;
    logic [NUM_NEURONS-1:0][WIDTH-1:0]      weight;
    logic [NUM_NEURONS-1:0][RW-1:0]         refrac;
    logic [VW-1:0]                          thresh;
    logic [NUM_NEURONS-1:0]                 spk_nxt;

    logic [VW-1:0]    v_nxt;
    logic [RW-1:0]    refrac_nxt;
    logic             fire;
    logic [WIDTH-1:0] w_adj;
    logic             last;

    assign cfg_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign last      = (idx == IW'(NUM_NEURONS - 1));
    assign w_adj     = rew_pos_q ? WIDTH'(sat_add(32'(weight[idx]), 32'd1, WMAX))
                                 : WIDTH'(sat_sub(32'(weight[idx]), 32'd1));

    snn_lif_update #(
        .WIDTH(WIDTH), .LEAK_SHIFT(LEAK_SHIFT), .REFRAC_STEPS(REFRAC_STEPS), .VW(VW), .RW(RW)
    ) u_lif (
        .v          (vmem[idx]),
        .w          (weight[idx]),
        .spk        (spk_in_q[idx]),
        .refrac     (refrac[idx]),
        .thresh     (thresh),
        .v_nxt      (v_nxt),
        .refrac_nxt (refrac_nxt),
        .fire       (fire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            spk_in_q  <= '0;
            rew_pos_q <= 1'b0;
            vmem      <= '0;
            weight    <= {NUM_NEURONS{WIDTH'(WEIGHT_INIT)}};
            refrac    <= '0;
            thresh    <= VW'(THRESH_INIT);
            spk_nxt   <= '0;
            spk_out   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A config write and a step on the same edge: the step sees the new value.
                    if (cfg_we) begin
                        if (cfg_sel == CFG_THRESH) thresh <= cfg_data;
                        else                       weight[cfg_addr] <= cfg_data[WIDTH-1:0];
                    end
                    if (step_i) begin
                        spk_in_q  <= spk_in;
                        rew_pos_q <= reward_pos;
                        idx       <= '0;
                        state     <= reward_valid ? ST_REWARD : ST_UPDATE;
                    end
                end
                ST_REWARD: begin
                    if (spk_out[idx]) weight[idx] <= w_adj;
                    idx <= idx + IW'(1);
                    if (last) state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    vmem[idx]    <= v_nxt;
                    refrac[idx]  <= refrac_nxt;
                    spk_nxt[idx] <= fire;
                    idx          <= idx + IW'(1);
                    if (last) state <= ST_DONE;
                end
                default: begin
                    spk_out <= spk_nxt;
                    spk_nxt <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_snn_lif_scheduler.sv
// Directed plus randomized checks of the LIF scheduler against a per-timestep arithmetic model.
module tb_snn_lif_scheduler;
    localparam int N    = 4;
    localparam int VMAX = 255;
    localparam int WMAX = 15;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         step_i, reward_valid, reward_pos, cfg_we, cfg_sel;
    logic [N-1:0] spk_in;
    logic [1:0]   cfg_addr;
    logic [7:0]   cfg_data;
    logic         cfg_ready, busy, done;
    logic [N-1:0] spk_out;

    int n_pass = 0;
    int n_chk  = 0;

    int           m_v[N];
    int           m_w[N];
    int           m_ref[N];
    int           m_th;
    logic [N-1:0] m_spk;

    always #5 clk = ~clk;

    snn_lif_scheduler dut (
        .clk(clk), .rst_n(rst_n), .step_i(step_i), .spk_in(spk_in),
        .reward_valid(reward_valid), .reward_pos(reward_pos),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .busy(busy), .done(done), .spk_out(spk_out)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0; m_w[i] = 4; m_ref[i] = 0;
        end
        m_th  = 8;
        m_spk = '0;
    endtask

    task automatic model_cfg(input logic sel, input int addr, input int data);
        if (sel) m_th = data;
        else     m_w[addr] = data % 16;
    endtask

    task automatic model_step(input logic [N-1:0] s, input logic rv, input logic rp);
        int vl, vn;
        logic [N-1:0] f;
        f = '0;
        if (rv)
            for (int i = 0; i < N; i++)
                if (m_spk[i]) begin
                    if (rp) m_w[i] = (m_w[i] >= WMAX) ? WMAX : m_w[i] + 1;
                    else    m_w[i] = (m_w[i] <= 0) ? 0 : m_w[i] - 1;
                end
        for (int i = 0; i < N; i++) begin
            vl = m_v[i] - m_v[i] / 4;
            if (m_ref[i] > 0) begin
                m_v[i] = vl;
                m_ref[i]--;
            end else begin
                vn = vl + (s[i] ? m_w[i] : 0);
                if (vn > VMAX) vn = VMAX;
                if (vn > m_th) begin
                    f[i] = 1'b1; m_v[i] = 0; m_ref[i] = 1;
                end else begin
                    m_v[i] = vn;
                end
            end
        end
        m_spk = f;
    endtask

    task automatic compare_state(input string tag);
        check({tag, ".spk_out"}, int'(spk_out), int'(m_spk));
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s.vmem%0d", tag, i), int'(dut.vmem[i]), m_v[i]);
            check($sformatf("%s.w%0d", tag, i), int'(dut.weight[i]), m_w[i]);
        end
        check({tag, ".thresh"}, int'(dut.thresh), m_th);
    endtask

    task automatic cfg_write(input logic sel, input int addr, input int data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = 2'(addr); cfg_data = 8'(data);
        @(negedge clk);
        cfg_we = 1'b0;
        model_cfg(sel, addr, data);
    endtask

    // Launch one timestep from IDLE (at a negedge), optionally with a same-edge cfg write
    // or a step/cfg pulse injected mid-sweep, then check latency and resulting state.
    task automatic do_step(input string tag, input logic [N-1:0] s, input logic rv,
                           input logic rp, input logic cw, input logic csel, input int caddr,
                           input int cdata, input logic inject);
        int lat;
        step_i = 1'b1; spk_in = s; reward_valid = rv; reward_pos = rp;
        cfg_we = cw; cfg_sel = csel; cfg_addr = 2'(caddr); cfg_data = 8'(cdata);
        if (cw) model_cfg(csel, caddr, cdata);
        model_step(s, rv, rp);
        @(negedge clk);
        step_i = 1'b0; cfg_we = 1'b0; spk_in = $urandom_range(0, 15);
        lat = 1;
        check({tag, ".busy_nordy"}, int'({busy, cfg_ready}), 2);
        while (done !== 1'b1 && lat < 40) begin
            if (inject && lat == 2) begin
                step_i = 1'b1; cfg_we = 1'b1; cfg_sel = 1'b1; cfg_data = 8'd0;
            end
            @(negedge clk);
            lat++;
            step_i = 1'b0; cfg_we = 1'b0;
        end
        check({tag, ".latency"}, lat, rv ? 2 * N + 1 : N + 1);
        @(negedge clk);
        check({tag, ".done_pulse"}, int'({done, busy}), 0);
        compare_state(tag);
    endtask

    initial begin
        int extra;
        rst_n = 1'b0; step_i = 1'b0; spk_in = '0; reward_valid = 1'b0; reward_pos = 1'b0;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst.outs", int'({busy, done, spk_out, cfg_ready}), 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rel.outs", int'({busy, done, spk_out, cfg_ready}), 1);
        compare_state("rst");

        // Integrate to threshold: 4, 7, then 10 > 8 fires.
        do_step("int1", 4'b0001, 0, 0, 0, 0, 0, 0, 0);
        check("int1.v0", int'(dut.vmem[0]), 4);
        do_step("int2", 4'b0001, 0, 0, 0, 0, 0, 0, 0);
        check("int2.v0", int'(dut.vmem[0]), 7);
        do_step("int3", 4'b0001, 0, 0, 0, 0, 0, 0, 0);
        check("int3.fire", int'(spk_out), 1);
        check("int3.v0", int'(dut.vmem[0]), 0);

        // Potentiate the neuron that just fired; it is refractory during this sweep.
        do_step("rew", 4'b0001, 1, 1, 0, 0, 0, 0, 0);
        check("rew.w0", int'(dut.weight[0]), 5);
        check("rew.w1", int'(dut.weight[1]), 4);
        check("refr.v0", int'(dut.vmem[0]), 0);
        do_step("post_refr", 4'b0001, 0, 0, 0, 0, 0, 0, 0);
        check("post_refr.v0", int'(dut.vmem[0]), 5);

        // Depress saturating at zero.
        cfg_write(1, 0, 0);
        do_step("fire_lo", 4'b0001, 0, 0, 0, 0, 0, 0, 0);
        cfg_write(0, 0, 0);
        do_step("dep0", 4'b0000, 1, 0, 0, 0, 0, 0, 0);
        check("dep0.w0", int'(dut.weight[0]), 0);

        // Max weight with max threshold never fires.
        cfg_write(1, 0, 255);
        cfg_write(0, 0, 15);
        for (int k = 0; k < 40; k++) do_step("sat", 4'b0001, 0, 0, 0, 0, 0, 0, 0);
        check("sat.nofire", int'(spk_out), 0);

        // Step/cfg pulses mid-sweep are dropped; no extra done follows.
        do_step("coll", 4'b0001, 0, 0, 0, 0, 0, 0, 1);
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        check("coll.no_extra_done", extra, 0);

        // Same-edge cfg + step: the lowered threshold applies to this sweep.
        do_step("same_edge", 4'b0001, 0, 0, 1, 1, 0, 0, 0);
        check("same_edge.fire", int'(spk_out[0]), 1);

        for (int k = 0; k < 30; k++) begin
            logic cw;
            cw = ($urandom_range(0, 3) == 0);
            do_step($sformatf("rnd%0d", k), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), cw,
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    int'($urandom_range(4, 40)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a sweep aborts with no partial commit.
        step_i = 1'b1; spk_in = 4'b1111;
        @(negedge clk);
        step_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst.outs", int'({busy, done, spk_out, cfg_ready}), 1);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        compare_state("midrst");
        do_step("after_rst", 4'b0001, 0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
